uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter.sv | 152 +++++++++++++++
 tb/tb_uart_transmitter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8E1/8E2 UART transmitter with one-entry holding register
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       send,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
  localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

  state_t      state;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic        stop_idx;
  logic [7:0]  shifter;
  logic        parity_bit;
  logic [7:0]  hold_data;
  logic        hold_full;

  logic tick;
  logic last_stop;
  logic load;
  logic accept;

  // A byte only enters through the holding register; the shifter is loaded
  // from it when idle or exactly as the last stop bit ends (zero-gap chaining).
  assign tick      = (bit_cnt == LAST_CNT);
  assign last_stop = (state == STOP) && tick && (stop_idx == LAST_STOP);
  assign load      = hold_full && ((state == IDLE) || last_stop);
  assign accept    = send && !hold_full;
  assign ready     = !hold_full;

  // Holding register: load empties it, accept fills it (never on the same edge).
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_data <= data;
    end
  end

  // Frame sequencer; tx, busy and done are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 16'd0;
      bit_idx    <= 3'd0;
      stop_idx   <= 1'b0;
      shifter    <= 8'h00;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          bit_cnt <= 16'd0;
          if (load) begin
            state      <= START;
            shifter    <= hold_data;
            parity_bit <= ^hold_data;
            tx         <= 1'b0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            state   <= DATA;
            tx      <= shifter[0];
            shifter <= {1'b0, shifter[7:1]};
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        DATA: begin
          if (tick) begin
            bit_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
              state   <= PARITY;
              tx      <= parity_bit;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shifter[0];
              shifter <= {1'b0, shifter[7:1]};
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        PARITY: begin
          if (tick) begin
            bit_cnt  <= 16'd0;
            stop_idx <= 1'b0;
            state    <= STOP;
            tx       <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        STOP: begin
          if (tick) begin
            bit_cnt <= 16'd0;
            if (stop_idx != LAST_STOP) begin
              stop_idx <= stop_idx + 1'b1;
            end else begin
              stop_idx <= 1'b0;
              done     <= 1'b1;
              if (load) begin
                state      <= START;
                shifter    <= hold_data;
                parity_bit <= ^hold_data;
                tx         <= 1'b0;
              end else begin
                state <= IDLE;
                tx    <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - bench for uart_transmitter
module tb_uart_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, send1, ready1, tx1, busy1, done1;
  logic [7:0] data1;
  logic       rst4, send4, ready4, tx4, busy4, done4;
  logic [7:0] data4;

  uart_transmitter #(.CLKS_PER_BIT(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst1), .data(data1), .send(send1),
    .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
  );

  uart_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut4 (
    .clk(clk), .rst(rst4), .data(data4), .send(send4),
    .ready(ready4), .tx(tx4), .busy(busy4), .done(done4)
  );

  typedef struct {
    logic [7:0]  data;
    logic        exp_par;
    logic [10:0] exp_frame;
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int fails  = 0;

  logic       tr_tx[64], tr_busy[64], tr_done[64], tr_ready[64];
  logic       drv_send[64], drv_rst[64];
  logic [7:0] drv_data[64];

  int rx_pos = -1;
  logic [7:0] rx_sh;
  logic       rx_par;
  logic       rx_en = 1'b0;
  logic [7:0] rx_bytes[$];
  logic       rx_errs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_drv();
    for (int i = 0; i < 64; i++) begin
      drv_send[i] = 1'b0;
      drv_rst[i]  = 1'b0;
      drv_data[i] = 8'h00;
    end
  endtask

  // Index c: inputs applied just after edge c, outputs sampled at the following negedge.
  task automatic run_trace(input int which, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      if (which == 0) begin
        send1 = drv_send[c]; data1 = drv_data[c]; rst1 = drv_rst[c];
      end else begin
        send4 = drv_send[c]; data4 = drv_data[c]; rst4 = drv_rst[c];
      end
      @(negedge clk);
      if (which == 0) begin
        tr_tx[c] = tx1; tr_busy[c] = busy1; tr_done[c] = done1; tr_ready[c] = ready1;
      end else begin
        tr_tx[c] = tx4; tr_busy[c] = busy4; tr_done[c] = done4; tr_ready[c] = ready4;
      end
    end
  endtask

  // Bench receiver for loopback, sampling mid-bit on negedge at one clk per bit.
  always @(negedge clk) begin
    if (rx_en) begin
      if (rx_pos < 0) begin
        if (tx1 == 1'b0) rx_pos = 0;
      end else if (rx_pos < 8) begin
        rx_sh[rx_pos] = tx1;
        rx_pos++;
      end else if (rx_pos == 8) begin
        rx_par = tx1;
        rx_pos++;
      end else begin
        rx_bytes.push_back(rx_sh);
        rx_errs.push_back((tx1 != 1'b1) || (rx_par != ^rx_sh));
        rx_pos = -1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [10:0] got;
    logic [21:0] got22;
    logic [11:0] frame4;
    logic [7:0]  q[$];
    logic        will;
    int nb, nd, nbad;

    vecs[0] = '{8'hA5, 1'b0, 11'b1_0_10100101_0};
    vecs[1] = '{8'h01, 1'b1, 11'b1_1_00000001_0};
    vecs[2] = '{8'h00, 1'b0, 11'b1_0_00000000_0};
    vecs[3] = '{8'hFF, 1'b0, 11'b1_0_11111111_0};
    vecs[4] = '{8'h80, 1'b1, 11'b1_1_10000000_0};
    vecs[5] = '{8'h3C, 1'b0, 11'b1_0_00111100_0};
    vecs[6] = '{8'h7F, 1'b1, 11'b1_1_01111111_0};

    rst1 = 1'b1; send1 = 1'b0; data1 = 8'h00;
    rst4 = 1'b1; send4 = 1'b0; data4 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst1 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    check("reset_state_1", {tx1, ready1, busy1, done1}, 4'b1100);
    check("reset_state_4", {tx4, ready4, busy4, done4}, 4'b1100);

    // Single frames from idle at one clk per bit.
    for (int v = 0; v < 7; v++) begin
      clear_drv();
      @(negedge clk);
      send1 = 1'b1; data1 = vecs[v].data;
      run_trace(0, 14);
      for (int i = 0; i < 11; i++) got[i] = tr_tx[i + 1];
      check($sformatf("frame_%02h", vecs[v].data), 32'(got), 32'(vecs[v].exp_frame));
      check($sformatf("parity_%02h", vecs[v].data), 32'(tr_tx[10]), 32'(vecs[v].exp_par));
      check($sformatf("latency_%02h", vecs[v].data), {tr_tx[0], tr_ready[0], tr_busy[0]}, 3'b100);
      nb = 0; nd = 0;
      for (int i = 0; i < 14; i++) begin
        nb += int'(tr_busy[i]);
        nd += int'(tr_done[i]);
      end
      check($sformatf("busy_cycles_%02h", vecs[v].data), nb, 11);
      check($sformatf("done_count_%02h", vecs[v].data), nd, 1);
      check($sformatf("done_pos_%02h", vecs[v].data), {tr_done[12], tr_busy[11], tr_busy[12], tr_tx[12]}, 4'b1101);
    end

    // Back-to-back 0x55 then 0xAA: send held high, second byte accepted once ready returns.
    clear_drv();
    drv_send[0] = 1'b1; drv_data[0] = 8'hAA;
    drv_send[1] = 1'b1; drv_data[1] = 8'hAA;
    @(negedge clk);
    send1 = 1'b1; data1 = 8'h55;
    run_trace(0, 26);
    for (int i = 0; i < 22; i++) got22[i] = tr_tx[i + 1];
    check("b2b_frames", 32'(got22), 32'({11'b1_0_10101010_0, 11'b1_0_01010101_0}));
    check("b2b_ready_after_load", {tr_ready[0], tr_ready[1]}, 2'b01);
    nb = 0; nd = 0;
    for (int i = 0; i < 26; i++) begin
      nb += int'(tr_busy[i]);
      nd += int'(tr_done[i]);
    end
    check("b2b_busy_cycles", nb, 22);
    check("b2b_done_count", nd, 2);
    check("b2b_done_pos", {tr_done[12], tr_done[23], tr_busy[22], tr_busy[23]}, 4'b1110);

    // Accept on the edge that ends the last stop bit: one idle cycle, then start.
    clear_drv();
    drv_send[11] = 1'b1; drv_data[11] = 8'h80;
    @(negedge clk);
    send1 = 1'b1; data1 = 8'h01;
    run_trace(0, 27);
    check("same_edge_ready", 32'(tr_ready[11]), 32'd1);
    check("same_edge_idle", {tr_done[12], tr_tx[12], tr_busy[12]}, 3'b110);
    for (int i = 0; i < 11; i++) got[i] = tr_tx[13 + i];
    check("same_edge_frame2", 32'(got), 32'(11'b1_1_10000000_0));
    check("same_edge_done2", {tr_done[24], tr_busy[24]}, 2'b10);

    // Reset during data bit 5 of 0xFF, then reset together with send.
    clear_drv();
    drv_rst[7]  = 1'b1;
    drv_rst[14] = 1'b1; drv_send[14] = 1'b1; drv_data[14] = 8'h00;
    @(negedge clk);
    send1 = 1'b1; data1 = 8'hFF;
    run_trace(0, 22);
    check("rst_midframe_before", {tr_tx[7], tr_busy[7]}, 2'b11);
    check("rst_midframe_after", {tr_tx[8], tr_ready[8], tr_busy[8]}, 3'b110);
    nd = 0;
    for (int i = 0; i < 22; i++) nd += int'(tr_done[i]);
    check("rst_no_done", nd, 0);
    check("rst_drops_send", {tr_ready[15], tr_tx[16], tr_busy[16], tr_tx[17]}, 4'b1101);
    clear_drv();
    @(negedge clk);
    send1 = 1'b1; data1 = 8'h3C;
    run_trace(0, 14);
    for (int i = 0; i < 11; i++) got[i] = tr_tx[i + 1];
    check("rst_clean_frame", 32'(got), 32'(11'b1_0_00111100_0));
    check("rst_clean_done", 32'(tr_done[12]), 32'd1);

    // Four clks per bit, two stop bits, 0x3C.
    clear_drv();
    frame4 = 12'b11_0_00111100_0;
    @(negedge clk);
    send4 = 1'b1; data4 = 8'h3C;
    run_trace(1, 52);
    nbad = 0;
    for (int k = 1; k <= 48; k++) if (tr_tx[k] !== frame4[(k - 1) / 4]) nbad++;
    check("cpb4_bit_hold", nbad, 0);
    check("cpb4_edges", {tr_tx[0], tr_tx[1], tr_tx[48], tr_tx[49]}, 4'b1011);
    nb = 0; nd = 0;
    for (int i = 0; i < 52; i++) begin
      nb += int'(tr_busy[i]);
      nd += int'(tr_done[i]);
    end
    check("cpb4_busy_cycles", nb, 48);
    check("cpb4_done", {tr_done[49], tr_busy[48], tr_busy[49]}, 3'b110);
    check("cpb4_done_count", nd, 1);

    // Loopback into the bench receiver: 0x00, 0x3C, 0xFF back-to-back.
    q = '{8'h00, 8'h3C, 8'hFF};
    rx_pos = -1;
    rx_en  = 1'b1;
    for (int cyc = 0; cyc < 80 && rx_bytes.size() < 3; cyc++) begin
      @(negedge clk);
      if (q.size() > 0) begin
        send1 = 1'b1; data1 = q[0];
      end else begin
        send1 = 1'b0;
      end
      will = send1 && ready1;
      @(posedge clk);
      if (will) void'(q.pop_front());
    end
    #1 send1 = 1'b0;
    rx_en = 1'b0;
    check("loop_count", rx_bytes.size(), 3);
    q = '{8'h00, 8'h3C, 8'hFF};
    for (int i = 0; i < rx_bytes.size() && i < 3; i++) begin
      check($sformatf("loop_byte_%0d", i), 32'(rx_bytes[i]), 32'(q[i]));
      check($sformatf("loop_err_%0d", i), 32'(rx_errs[i]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
